uart_rx_core: RTL and testbench
===============================

# uart_rx_core

UART receiver DUT that is the far end of the UART transmitter on the `uart_if` bench interface. It samples the serial line, recovers 5–8 bit frames (start, data LSB-first, one stop bit, no parity) using the same `cfg_en_i` / `cfg_bits_i` / `cfg_div_i` configuration as the transmitter, and presents each byte on a valid/ready handshake. It reports framing and overrun errors so the slave monitor can check the line against the master driver.

## Interface
- No parameters. Data width is fixed at 8 and the divider width at 16.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: **asynchronous, active-low reset**.
- `rx_i` in 1: serial line, idle high, asynchronous to `clock`.
- `cfg_en_i` in 1: receiver enable.
- `cfg_bits_i` in 2: data bits per frame: 00=5, 01=6, 10=7, 11=8.
- `cfg_div_i` in 16: clock cycles per bit.
- `rx_data_o` out 8: received byte, right-aligned, with unused upper bits driven 0.
- `rx_valid_o` out 1: `rx_data_o` holds an unconsumed byte.
- `rx_ready_i` in 1: consumer accepts the byte.
- `busy_o` out 1: high while a frame is in progress (any state other than IDLE).
- `frame_err_o` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_o` out 1: one-cycle pulse when a completed byte is dropped.

## Operation
- `rx_i` passes through a 2-flop synchronizer. All logic uses the synchronized `rxs`.
- The FSM has five states: IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE**: on `cfg_en_i`=1 and `rxs`=0, latch `cfg_bits_i`, latch the effective divider `D = max(cfg_div_i, 4)`, load the baud counter with `H = D>>1`, then go to START.
- **START**: when the counter expires, sample `rxs`.
  - Low: reload the counter with D, clear the bit index, go to DATA.
  - High: treat as a glitch and return to IDLE. No outputs are produced.
- **DATA**: each time the counter expires, shift `rxs` in LSB-first, increment the index, and reload D. After N bits go to STOP.
- **STOP**: when the counter expires, sample `rxs`.
  - High: complete the frame and go to IDLE.
  - Low: pulse `frame_err_o`, still complete the frame, go to WAIT_HIGH.
- **WAIT_HIGH**: stay until `rxs`=1, then go to IDLE. This blocks break conditions from being read as back-to-back start bits.
- **Completion**:
  - If `rx_valid_o`=0: load `rx_data_o` and set `rx_valid_o`.
  - If `rx_valid_o`=1 and `rx_ready_i`=0 on that cycle: pulse `overrun_o`, discard the new byte, and keep the old one.
  - If `rx_valid_o`=1 and `rx_ready_i`=1 on the completion cycle: accept the old byte and load the new one. `rx_valid_o` stays 1 and no overrun is reported.
- **Handshake**: a transfer occurs on any cycle with `rx_valid_o`=1 and `rx_ready_i`=1. `rx_valid_o` clears the next cycle unless a completion occurs on the same cycle. `rx_data_o` is stable while `rx_valid_o`=1 and unaccepted.
- **`cfg_en_i`=0**: the FSM is forced to IDLE the next cycle and any in-flight frame is discarded silently. A pending `rx_valid_o`/`rx_data_o` is retained until accepted.
- **Config changes**: changes mid-frame have no effect until the next start detection.

## Timing
- **Reset values**: `rx_data_o`=0, `rx_valid_o`=0, `busy_o`=0, `frame_err_o`=0, `overrun_o`=0, FSM=IDLE, synchronizer flops=1.
- **Reset mid-frame**: all of the above take effect immediately (asynchronously). The byte is lost and no error is flagged.
- **Sample points**: t0 is the first cycle `rxs`=0 in IDLE.
  - Start sample at t0+H.
  - Data bit k (k=1..N) at t0+H+k·D.
  - Stop sample at t0+H+(N+1)·D.
- **Outputs after the stop sample**: `rx_valid_o`, `frame_err_o` and `overrun_o` assert at stop sample +1 cycle.
- **End-to-end latency**: from the `rx_i` falling edge this is +2 cycles of synchronizer delay.
- **`busy_o`**: high from t0+1 until the cycle after the return to IDLE.
- **Back-to-back frames**: a start bit immediately following a valid stop is detected, because IDLE is re-entered at stop sample +1.
- **Counter and index widths**: the baud counter is 16-bit and counts down to 1. The bit index is 3-bit, and the `cfg_bits_i`=11 case terminates at index 7 without overflow.

## Test plan
- **Basic frame**: D=16, 8 bits, frame 0xA5 with `rx_ready_i`=0 -> `rx_data_o`=0xA5 and `rx_valid_o`=1 at t0+153. Data holds until `rx_ready_i`=1, then valid clears the next cycle.
- **5-bit frame**: `cfg_bits_i`=00, D=8, data bits 1,0,1,1,0 -> `rx_data_o`=0x0D with upper bits 0, and valid at t0+4+48+1.
- **Glitch on the line**: `rx_i` low for 3 cycles, D=16 -> `busy_o` pulses, then returns to 0 at about t0+9. No valid and no errors.
- **Framing error and break**: D=16, frame 0x3C with the stop bit low, line held low for 40 more cycles, then high, then frame 0x55 ->
  - `frame_err_o` pulses once and 0x3C is delivered.
  - No spurious frame during the low hold.
  - 0x55 is received correctly.
- **Overrun**: two back-to-back frames 0x11 then 0x22 with `rx_ready_i`=0 -> `overrun_o` pulses at the second completion and `rx_data_o` remains 0x11. Repeat with `rx_ready_i`=1 asserted exactly on the second completion cycle -> 0x11 is accepted, 0x22 is loaded, and there is no overrun.
- **Abort**: drop `cfg_en_i` mid-DATA, or assert `reset` mid-DATA -> the FSM is in IDLE the next cycle (immediately for reset). No `rx_valid_o` and no error pulses, and the next clean frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM for 5..8 data bits,
// one stop bit, valid/ready output holding register with framing/overrun pulses.
module uart_rx_core (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_i,
  input  logic        cfg_en_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic [15:0] cfg_div_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        busy_o,
  output logic        frame_err_o,
  output logic        overrun_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  // Dividers below 4 would collapse the half-bit start offset, so clamp them.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < 16'd4) ? 16'd4 : div;
  endfunction

  logic        sync1_r;
  logic        rxs_r;
  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic [2:0]  idx_r;
  logic [2:0]  idx_nxt_s;
  logic [7:0]  shreg_r;
  logic [7:0]  shreg_nxt_s;
  logic [1:0]  bits_r;
  logic [1:0]  bits_nxt_s;
  logic [15:0] div_r;
  logic [15:0] div_nxt_s;
  logic        done_s;
  logic        ferr_s;
  logic        cnt_exp_s;
  logic [2:0]  last_idx_s;

  assign cnt_exp_s  = (cnt_r == 16'd1);
  assign last_idx_s = {1'b1, bits_r};

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= rx_i;
      rxs_r   <= sync1_r;
    end
  end

  // FSM and frame datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      idx_r   <= 3'd0;
      shreg_r <= 8'h00;
      bits_r  <= 2'd0;
      div_r   <= 16'd4;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shreg_r <= shreg_nxt_s;
      bits_r  <= bits_nxt_s;
      div_r   <= div_nxt_s;
    end
  end

  // Next-state, counter reload and completion strobes.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    shreg_nxt_s = shreg_r;
    bits_nxt_s  = bits_r;
    div_nxt_s   = div_r;
    done_s      = 1'b0;
    ferr_s      = 1'b0;
    if (cnt_r > 16'd1) begin
      cnt_nxt_s = cnt_r - 16'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end

    if (cfg_en_i) begin
      case (state_r)
        IDLE: begin
          if (!rxs_r) begin
            bits_nxt_s  = cfg_bits_i;
            div_nxt_s   = eff_div(cfg_div_i);
            cnt_nxt_s   = eff_div(cfg_div_i) >> 1;
            shreg_nxt_s = 8'h00;
            state_nxt_s = START;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        START: begin
          if (cnt_exp_s) begin
            if (!rxs_r) begin
              cnt_nxt_s   = div_r;
              idx_nxt_s   = 3'd0;
              state_nxt_s = DATA;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            state_nxt_s = START;
          end
        end
        DATA: begin
          if (cnt_exp_s) begin
            shreg_nxt_s[idx_r] = rxs_r;
            cnt_nxt_s          = div_r;
            if (idx_r == last_idx_s) begin
              state_nxt_s = STOP;
            end else begin
              idx_nxt_s = idx_r + 3'd1;
            end
          end else begin
            state_nxt_s = DATA;
          end
        end
        STOP: begin
          if (cnt_exp_s) begin
            done_s = 1'b1;
            if (rxs_r) begin
              state_nxt_s = IDLE;
            end else begin
              ferr_s      = 1'b1;
              state_nxt_s = WAIT_HIGH;
            end
          end else begin
            state_nxt_s = STOP;
          end
        end
        WAIT_HIGH: begin
          if (rxs_r) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = WAIT_HIGH;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      // Disabled: abandon any frame in flight without reporting anything.
      state_nxt_s = IDLE;
    end
  end

  // Output holding register, handshake and error pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_data_o   <= 8'h00;
      rx_valid_o  <= 1'b0;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      busy_o      <= (state_nxt_s != IDLE);
      frame_err_o <= ferr_s;
      overrun_o   <= done_s & rx_valid_o & ~rx_ready_i;
      if (done_s && (!rx_valid_o || rx_ready_i)) begin
        rx_data_o  <= shreg_r;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end else begin
        rx_valid_o <= rx_valid_o;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: vector table, corner-case sequences
// and randomized frames checked against a byte-level reference model.
module tb_uart_rx_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_i;
  logic        cfg_en_i;
  logic [1:0]  cfg_bits_i;
  logic [15:0] cfg_div_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        busy_o;
  logic        frame_err_o;
  logic        overrun_o;

  uart_rx_core dut (
    .clock       (clock),
    .reset       (reset),
    .rx_i        (rx_i),
    .cfg_en_i    (cfg_en_i),
    .cfg_bits_i  (cfg_bits_i),
    .cfg_div_i   (cfg_div_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_fall = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: valid rise time, error pulse counts, accepted bytes.
  logic       prev_valid = 1'b0;
  int         rise_cyc = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         acc_n    = 0;
  logic [7:0] acc_mem [0:255];

  always @(negedge clock) begin
    if (rx_valid_o && !prev_valid) rise_cyc <= cyc;
    if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
    if (overrun_o) ovr_cnt <= ovr_cnt + 1;
    if (rx_valid_o && rx_ready_i) begin
      acc_mem[acc_n[7:0]] <= rx_data_o;
      acc_n <= acc_n + 1;
    end
    prev_valid <= rx_valid_o;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drive one frame; the stop level is held for per+hold cycles, then the line idles high.
  task automatic send_frame(input logic [7:0] d, input int n, input int per,
                            input logic stopb, input int hold);
    t_fall = cyc;
    rx_i = 1'b0;
    tick(per);
    for (int i = 0; i < n; i++) begin
      rx_i = d[i];
      tick(per);
    end
    rx_i = stopb;
    tick(per + hold);
    rx_i = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  bits;
    logic [15:0] div;
    int          per;
    logic [7:0]  data;
    logic        stopb;
    logic [7:0]  exp_data;
    logic        exp_ferr;
    int          exp_lat;
  } vec_t;

  vec_t vt [6];

  int         f0, o0, a0, nfr, dv, per;
  logic [1:0] rb;
  logic [7:0] rd;
  logic [7:0] exp_q [$];

  initial begin
    // latency from rx_i fall = 2 (sync) + D/2 + (N+1)*D + 1
    vt[0] = '{2'b11, 16'd16, 16, 8'hA5, 1'b1, 8'hA5, 1'b0, 155};
    vt[1] = '{2'b00, 16'd8,   8, 8'hED, 1'b1, 8'h0D, 1'b0, 55};
    vt[2] = '{2'b01, 16'd10, 10, 8'hFF, 1'b1, 8'h3F, 1'b0, 78};
    vt[3] = '{2'b10, 16'd2,   4, 8'h81, 1'b1, 8'h01, 1'b0, 37};
    vt[4] = '{2'b11, 16'd5,   5, 8'h5A, 1'b1, 8'h5A, 1'b0, 50};
    vt[5] = '{2'b11, 16'd12, 12, 8'hC3, 1'b0, 8'hC3, 1'b1, 117};

    reset = 1'b0;
    rx_i = 1'b1;
    cfg_en_i = 1'b1;
    cfg_bits_i = 2'b11;
    cfg_div_i = 16'd16;
    rx_ready_i = 1'b0;
    tick(3);
    chk("reset_data", 32'(rx_data_o), 32'h0);
    chk("reset_valid", 32'(rx_valid_o), 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);
    chk("reset_ferr", 32'(frame_err_o), 32'h0);
    chk("reset_ovr", 32'(overrun_o), 32'h0);
    reset = 1'b1;
    tick(5);

    for (int i = 0; i < 6; i++) begin
      cfg_bits_i = vt[i].bits;
      cfg_div_i = vt[i].div;
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      send_frame(vt[i].data, 5 + int'(vt[i].bits), vt[i].per, vt[i].stopb, 0);
      tick(2);
      chk($sformatf("vec%0d_valid", i), 32'(rx_valid_o), 32'h1);
      chk($sformatf("vec%0d_data", i), 32'(rx_data_o), 32'(vt[i].exp_data));
      chk($sformatf("vec%0d_latency", i), 32'(rise_cyc - t_fall), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vt[i].exp_ferr));
      tick(10);
      chk($sformatf("vec%0d_hold_valid", i), 32'(rx_valid_o), 32'h1);
      chk($sformatf("vec%0d_hold_data", i), 32'(rx_data_o), 32'(vt[i].exp_data));
      rx_ready_i = 1'b1;
      tick(1);
      rx_ready_i = 1'b0;
      chk($sformatf("vec%0d_valid_clear", i), 32'(rx_valid_o), 32'h0);
      chk($sformatf("vec%0d_ovr", i), 32'(ovr_cnt - o0), 32'h0);
      tick(3);
    end

    // Glitch: 3 low cycles never reach the start sample.
    cfg_bits_i = 2'b11;
    cfg_div_i = 16'd16;
    f0 = ferr_cnt; o0 = ovr_cnt; a0 = acc_n;
    rx_i = 1'b0;
    tick(3);
    rx_i = 1'b1;
    tick(2);
    chk("glitch_busy_high", 32'(busy_o), 32'h1);
    tick(5);
    chk("glitch_busy_t8", 32'(busy_o), 32'h1);
    tick(1);
    chk("glitch_busy_t9", 32'(busy_o), 32'h0);
    tick(20);
    chk("glitch_valid", 32'(rx_valid_o), 32'h0);
    chk("glitch_err", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'h0);

    // Framing error, 40-cycle break, then a clean frame.
    rx_ready_i = 1'b1;
    f0 = ferr_cnt; o0 = ovr_cnt; a0 = acc_n;
    send_frame(8'h3C, 8, 16, 1'b0, 40);
    tick(5);
    send_frame(8'h55, 8, 16, 1'b1, 0);
    tick(5);
    rx_ready_i = 1'b0;
    chk("break_count", 32'(acc_n - a0), 32'h2);
    chk("break_first", 32'(acc_mem[a0[7:0]]), 32'h3C);
    chk("break_second", 32'(acc_mem[8'(a0 + 1)]), 32'h55);
    chk("break_ferr", 32'(ferr_cnt - f0), 32'h1);
    chk("break_ovr", 32'(ovr_cnt - o0), 32'h0);

    // Overrun: second byte dropped while the first is unread.
    o0 = ovr_cnt;
    send_frame(8'h11, 8, 16, 1'b1, 0);
    send_frame(8'h22, 8, 16, 1'b1, 0);
    tick(3);
    chk("ovr_pulse", 32'(ovr_cnt - o0), 32'h1);
    chk("ovr_data", 32'(rx_data_o), 32'h11);
    chk("ovr_valid", 32'(rx_valid_o), 32'h1);
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;
    chk("ovr_clear", 32'(rx_valid_o), 32'h0);

    // Accept exactly on the second completion cycle: no overrun.
    o0 = ovr_cnt;
    send_frame(8'h11, 8, 16, 1'b1, 0);
    a0 = acc_n;
    fork
      send_frame(8'h22, 8, 16, 1'b1, 0);
      begin
        tick(154);
        rx_ready_i = 1'b1;
        tick(1);
        rx_ready_i = 1'b0;
      end
    join
    tick(3);
    chk("sim_ovr", 32'(ovr_cnt - o0), 32'h0);
    chk("sim_valid", 32'(rx_valid_o), 32'h1);
    chk("sim_data", 32'(rx_data_o), 32'h22);
    chk("sim_accepted", 32'(acc_mem[a0[7:0]]), 32'h11);
    chk("sim_acc_count", 32'(acc_n - a0), 32'h1);
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;

    // Abort by disabling mid-DATA.
    f0 = ferr_cnt; o0 = ovr_cnt; a0 = acc_n;
    fork
      send_frame(8'h99, 8, 16, 1'b1, 0);
      begin
        tick(60);
        cfg_en_i = 1'b0;
        tick(1);
        chk("en_abort_idle", 32'(busy_o), 32'h0);
      end
    join
    tick(2);
    chk("en_abort_valid", 32'(rx_valid_o), 32'h0);
    chk("en_abort_err", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'h0);
    cfg_en_i = 1'b1;
    tick(2);
    send_frame(8'h7E, 8, 16, 1'b1, 0);
    tick(2);
    chk("en_after_data", 32'(rx_data_o), 32'h7E);
    chk("en_after_valid", 32'(rx_valid_o), 32'h1);

    // Abort by reset mid-DATA with a byte still pending.
    f0 = ferr_cnt;
    fork
      send_frame(8'hAA, 8, 16, 1'b1, 0);
      begin
        tick(60);
        #2 reset = 1'b0;
        #1;
        chk("rst_abort_busy", 32'(busy_o), 32'h0);
        chk("rst_abort_valid", 32'(rx_valid_o), 32'h0);
        chk("rst_abort_data", 32'(rx_data_o), 32'h0);
      end
    join
    reset = 1'b1;
    tick(3);
    chk("rst_abort_ferr", 32'(ferr_cnt - f0), 32'h0);
    send_frame(8'h7E, 8, 16, 1'b1, 0);
    tick(2);
    chk("rst_after_data", 32'(rx_data_o), 32'h7E);
    rx_ready_i = 1'b1;
    tick(1);

    // Random frames with an always-ready consumer; model is the masked byte.
    f0 = ferr_cnt; o0 = ovr_cnt; a0 = acc_n;
    nfr = 16;
    for (int i = 0; i < nfr; i++) begin
      rb = 2'($urandom_range(0, 3));
      dv = int'($urandom_range(0, 10));
      per = (dv < 4) ? 4 : dv;
      rd = 8'($urandom);
      cfg_bits_i = rb;
      cfg_div_i = 16'(dv);
      exp_q.push_back(rd & 8'((1 << (5 + int'(rb))) - 1));
      send_frame(rd, 5 + int'(rb), per, 1'b1, 0);
      tick(int'($urandom_range(0, 3)));
    end
    tick(20);
    rx_ready_i = 1'b0;
    chk("rand_count", 32'(acc_n - a0), 32'(nfr));
    for (int i = 0; i < nfr; i++) begin
      chk($sformatf("rand_byte%0d", i), 32'(acc_mem[8'(a0 + i)]), 32'(exp_q[i]));
    end
    chk("rand_err", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
